// File: rtl/restoring_divider.sv
// Sequential unsigned 10-by-5 restoring divider.
// Five shift/subtract iterations produce a 5-bit quotient and remainder.
// Overflow (X[9:5] >= D) and divide-by-zero are detected at capture and
// short-circuit straight to DONE with zeroed results.
`timescale 1ns/1ps
module restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] dividend,
  input  logic [4:0] divisor,
  output logic [4:0] quotient,
  output logic [4:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       ov,
  output logic       divBy0
);

  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;

  state_t     state, nxt;
  logic [5:0] pr;
  logic [4:0] qr;
  logic [4:0] dr;
  logic [2:0] cnt;

  // capture-time error detection; divide-by-zero masks overflow
  logic dz_in, ov_in, err_in;
  assign dz_in  = (divisor == 5'd0);
  assign ov_in  = (dividend[9:5] >= divisor) && !dz_in;
  assign err_in = dz_in || ov_in;

  // trial subtract PR - DR as PR + ~DR + 1; carry-out set means PR >= DR
  logic [6:0] diff;
  logic       c;
  logic [5:0] pr_sub;
  logic [4:0] qr_sub;
  assign diff   = {1'b0, pr} + {2'b01, ~dr} + 7'd1;
  assign c      = diff[6];
  assign pr_sub = c ? diff[5:0] : pr;
  assign qr_sub = c ? {qr[4:1], 1'b1} : qr;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next-state decode; start is only looked at in IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = err_in ? DONE : SHIFT;
      SHIFT: nxt = SUB;
      SUB:   nxt = (cnt == 3'd4) ? DONE : SHIFT;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // datapath: operand capture, shift/subtract iterations, result load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr        <= '0;
      qr        <= '0;
      dr        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ov        <= 1'b0;
      divBy0    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pr     <= {1'b0, dividend[9:5]};
          qr     <= dividend[4:0];
          dr     <= divisor;
          cnt    <= '0;
          ov     <= ov_in;
          divBy0 <= dz_in;
          // results of a failed operation read as zero
          if (err_in) begin
            quotient  <= '0;
            remainder <= '0;
          end
        end
        SHIFT: begin
          pr <= {pr[4:0], qr[4]};
          qr <= {qr[3:0], 1'b0};
        end
        SUB: begin
          pr <= pr_sub;
          qr <= qr_sub;
          if (cnt == 3'd4) begin
            quotient  <= qr_sub;
            remainder <= pr_sub[4:0];
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
